// File: rtl/stream_deserializer.sv
// stream_deserializer: regroups a valid-qualified byte stream into 8-byte frames,
// presented on eight parallel byte ports and held until acknowledged.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   COLLECT | filling the shadow frame; din_rdy=1; the idle timeout is armed
//           | while a partial frame is held
//   PENDING | complete frame parked in shadow, output still occupied;
//           | incoming bytes are dropped (overflow)
module stream_deserializer #(
   parameter int TIMEOUT = 16
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] din,
   input  logic       din_en,
   input  logic       frame_ack,
   output logic [7:0] b_0,
   output logic [7:0] b_1,
   output logic [7:0] b_2,
   output logic [7:0] b_3,
   output logic [7:0] b_4,
   output logic [7:0] b_5,
   output logic [7:0] b_6,
   output logic [7:0] b_7,
   output logic       frame_valid,
   output logic       din_rdy,
   output logic       frag_err,
   output logic       overflow,
   output logic [7:0] frame_cnt
);

   localparam int IW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
   // Count value on which the next idle cycle completes the timeout.
   localparam logic [IW-1:0] TO_LAST = (TIMEOUT > 0) ? IW'(TIMEOUT - 1) : '0;

   typedef enum logic {COLLECT = 1'b0, PENDING = 1'b1} state_t;

   state_t        state;
   logic [7:0]    shadow [8];
   logic [2:0]    wr_cnt;
   logic [IW-1:0] idle_cnt;
   logic          out_free;

   // The output register can take a new frame if empty or being released now.
   assign out_free = !frame_valid || frame_ack;
   assign din_rdy  = (state == COLLECT);

   // Collection FSM, shadow buffer, output frame register and status flags.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state       <= COLLECT;
         wr_cnt      <= '0;
         idle_cnt    <= '0;
         for (int i = 0; i < 8; i++) shadow[i] <= '0;
         b_0         <= '0;
         b_1         <= '0;
         b_2         <= '0;
         b_3         <= '0;
         b_4         <= '0;
         b_5         <= '0;
         b_6         <= '0;
         b_7         <= '0;
         frame_valid <= 1'b0;
         frag_err    <= 1'b0;
         overflow    <= 1'b0;
         frame_cnt   <= '0;
      end else begin
         frag_err <= 1'b0;
         case (state)
            COLLECT: begin
               if (din_en) begin
                  idle_cnt <= '0;
                  // 3-bit counter wraps 7 -> 0 at the end of every frame
                  wr_cnt   <= wr_cnt + 3'd1;
                  if (wr_cnt == 3'd7) begin
                     if (out_free) begin
                        // 8th byte bypasses the shadow straight into b_7
                        b_0         <= shadow[0];
                        b_1         <= shadow[1];
                        b_2         <= shadow[2];
                        b_3         <= shadow[3];
                        b_4         <= shadow[4];
                        b_5         <= shadow[5];
                        b_6         <= shadow[6];
                        b_7         <= din;
                        frame_valid <= 1'b1;
                        frame_cnt   <= frame_cnt + 8'd1;
                     end else begin
                        shadow[7] <= din;
                        state     <= PENDING;
                     end
                  end else begin
                     shadow[wr_cnt] <= din;
                     if (frame_ack) frame_valid <= 1'b0;
                  end
               end else begin
                  if (frame_ack) frame_valid <= 1'b0;
                  if (TIMEOUT > 0 && wr_cnt != 3'd0) begin
                     if (idle_cnt == TO_LAST) begin
                        wr_cnt   <= '0;
                        idle_cnt <= '0;
                        frag_err <= 1'b1;
                     end else begin
                        idle_cnt <= idle_cnt + IW'(1);
                     end
                  end else begin
                     idle_cnt <= '0;
                  end
               end
            end
            PENDING: begin
               idle_cnt <= '0;
               if (din_en) overflow <= 1'b1;
               // frame_valid is necessarily 1 here, so the ack always reloads
               if (frame_ack) begin
                  b_0       <= shadow[0];
                  b_1       <= shadow[1];
                  b_2       <= shadow[2];
                  b_3       <= shadow[3];
                  b_4       <= shadow[4];
                  b_5       <= shadow[5];
                  b_6       <= shadow[6];
                  b_7       <= shadow[7];
                  frame_cnt <= frame_cnt + 8'd1;
                  state     <= COLLECT;
               end
            end
            default: state <= COLLECT;
         endcase
      end
   end

endmodule

// File: doc/stream_deserializer.md
# stream_deserializer

Byte-stream-to-parallel collector that sits directly downstream of the 8-byte serializer wrapper in the FPGA CNN datapath. It accepts the serializer's `dout`/`outen` byte stream, regroups every 8 consecutive valid bytes into one frame, and presents that frame as eight parallel byte ports. The frame is held until the consumer acknowledges it. One shadow frame gives double buffering, and idle-timeout logic discards stalled partial frames.

## Interface
- `TIMEOUT`, default 16: number of idle cycles (no `din_en`) allowed inside a partial frame before it is discarded; 0 disables the timeout.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `din`  in  8  stream byte; connects to the serializer's `dout`.
- `din_en`  in  1  `din` valid this cycle; connects to the serializer's `outen`.
- `frame_ack`  in  1  consumer accepts the presented frame; ignored while `frame_valid`=0.
- `b_0` … `b_7`  out  8 each  frame bytes; `b_k` is the k-th byte received in the frame.
- `frame_valid`  out  1  `b_0`..`b_7` hold an unconsumed frame.
- `din_rdy`  out  1  1 in COLLECT, 0 in PENDING (informational; the upstream block has no backpressure).
- `frag_err`  out  1  one-cycle pulse when a partial frame is discarded by timeout.
- `overflow`  out  1  sticky; a byte was dropped in PENDING.
- `frame_cnt`  out  8  count of frames loaded into the output register; wraps 255→0.

## Operation
- Reset (`rst_n`=0 at an edge) sets all outputs and state to 0: `b_*`=0, `frame_valid`=0, `din_rdy`=1 after release, `frag_err`=0, `overflow`=0, `frame_cnt`=0. Internal state: `wr_cnt`=0, idle counter 0, state COLLECT. Reset mid-frame or mid-PENDING discards everything.
- **COLLECT.** Each `din_en` cycle writes `din` into shadow slot `wr_cnt`, then `wr_cnt` increments (3-bit).
- **8th byte** (`wr_cnt`=7 with `din_en`):
  - If the output is free (`frame_valid`=0, or `frame_valid`=1 with `frame_ack`=1 this cycle): load `b_0`..`b_6` from shadow and `b_7` from `din`; `frame_valid` goes to 1; `frame_cnt` increments; `wr_cnt` goes to 0; stay in COLLECT.
  - Otherwise: store the byte in shadow slot 7, `wr_cnt` goes to 0, enter PENDING.
- **PENDING** (complete frame in shadow, output occupied):
  - `din_rdy`=0.
  - Any `din_en` byte is dropped and `overflow` is set to 1 (held until reset).
  - On `frame_ack`: load output from shadow; `frame_valid` stays 1; `frame_cnt` increments; return to COLLECT. A `din_en` byte in that same ack cycle is dropped (`overflow` set).
- **frame_ack with no reload:** `frame_valid`=1 and `frame_ack`=1 with no load that cycle drives `frame_valid` to 0. `b_*` keep their last value.
- **Timeout** (TIMEOUT>0, COLLECT, 0<`wr_cnt`<8):
  - The idle counter increments on each cycle without `din_en` and clears on any `din_en`.
  - When it reaches TIMEOUT: `wr_cnt`←0, counter←0, `frag_err`=1 for exactly one cycle. The output frame is unaffected.
  - The counter is held at 0 when `wr_cnt`=0 or in PENDING.
- **Timeout and din_en together:** the byte wins and no timeout occurs that cycle.

## Timing
- Latency: `frame_valid` and the new `b_*` are visible the cycle after the edge that captures the 8th byte.
- Back-to-back frames (16 consecutive `din_en` cycles, with the consumer acking each frame the cycle `frame_valid` rises) produce no drop and no bubble.
- PENDING→output reload is visible the cycle after the `frame_ack` edge.
- `frag_err` is asserted the cycle after the edge on which the idle count reaches TIMEOUT.
- `frame_valid` may stay high across consecutive frames; the consumer distinguishes them by `frame_cnt`.

## Test plan
- **Reset then single frame.** Hold `rst_n`=0 for 3 cycles, release, then send bytes 0x00..0x07 on 8 consecutive `din_en` cycles. Required: `frame_valid`=1 one cycle later, `b_k`=k, `frame_cnt`=1, `overflow`=0.
- **Double buffer.** Send frame A (0x10..0x17) without ack, then frame B (0x20..0x27). Required: state PENDING and `din_rdy`=0, `b_*` still A. Then pulse `frame_ack`. Required: `b_*`=B the next cycle, `frame_valid` stays 1, `frame_cnt`=2.
- **Overflow.** From PENDING, send 1 more byte 0xAA. Required: `overflow`=1 and sticky, byte absent from all later frames, `frame_cnt` unchanged.
- **Timeout.** With TIMEOUT=16, send 3 bytes, then idle. Required: `frag_err` pulses exactly once, on the cycle after the 16th idle edge. Then send 0x30..0x37. Required: frame equals 0x30..0x37.
- **Ack/8th-byte coincidence and reset mid-frame.** Assert `frame_ack` on the same cycle as the 8th byte of the next frame. Required: direct load, no PENDING, `frame_valid` stays 1. Separately, apply `rst_n`=0 after 5 bytes. Required: all outputs 0, and the next 8 bytes form a clean frame.
- **Wrap.** Send 256 acked frames. Required: `frame_cnt` reads 0x00 after the 256th load.
